// File: rtl/pipe_pkg.sv
// Shared widths and state encoding for the IF/ID skid stage.
package pipe_pkg;

    localparam int DW = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } stage_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus payload register; load wins over clear.
// Clear drops only the valid bit, so the payload may stay stale.
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_dat,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= load_dat;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/ifid_skid_stage.sv
// Two-entry skid stage between fetch and decode, 1-cycle latency when empty.
// Up_Ready is registered (!skid valid), so Dn_Ready never reaches IF combinationally.
module ifid_skid_stage
    import pipe_pkg::*;
#(
    parameter int DW = pipe_pkg::DW
) (
    input  logic          Clk,
    input  logic          Rst_N,
    input  logic          Flush,
    input  logic          Up_Valid,
    output logic          Up_Ready,
    input  logic [DW-1:0] Up_Pc,
    input  logic [DW-1:0] Up_Instr,
    output logic          Dn_Valid,
    input  logic          Dn_Ready,
    output logic [DW-1:0] Dn_Pc,
    output logic [DW-1:0] Dn_Instr,
    output logic [1:0]    Occupancy
);

    stage_state_t state_q, state_d;

    logic            main_load, main_clear, main_from_skid;
    logic            skid_load, skid_clear;
    logic            main_vld, skid_vld;
    logic [2*DW-1:0] main_dat, skid_dat, main_load_dat;
    logic            accept, consume;

    assign Up_Ready  = !skid_vld;
    assign Dn_Valid  = main_vld;
    assign Dn_Pc     = main_dat[2*DW-1:DW];
    assign Dn_Instr  = main_dat[DW-1:0];
    assign Occupancy = state_q;

    assign accept  = Up_Valid & Up_Ready;
    assign consume = Dn_Valid & Dn_Ready;

    assign main_load_dat = main_from_skid ? skid_dat : {Up_Pc, Up_Instr};

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) state_q <= S_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        // A redirect discards everything, including this cycle's handshakes.
        if (Flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = S_FULL;
                    end else if (consume) begin
                        main_clear = 1'b1;
                        state_d    = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = S_ONE;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = S_EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(.W(2*DW)) u_main (
        .clk      (Clk),
        .rst_n    (Rst_N),
        .load     (main_load),
        .clear    (main_clear),
        .load_dat (main_load_dat),
        .vld      (main_vld),
        .dat      (main_dat)
    );

    pipe_slot #(.W(2*DW)) u_skid (
        .clk      (Clk),
        .rst_n    (Rst_N),
        .load     (skid_load),
        .clear    (skid_clear),
        .load_dat ({Up_Pc, Up_Instr}),
        .vld      (skid_vld),
        .dat      (skid_dat)
    );

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed and randomized checks of ifid_skid_stage against a queue model.
module tb_ifid_skid_stage;

    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst_N;
    logic          Flush;
    logic          Up_Valid;
    logic          Up_Ready;
    logic [DW-1:0] Up_Pc;
    logic [DW-1:0] Up_Instr;
    logic          Dn_Valid;
    logic          Dn_Ready;
    logic [DW-1:0] Dn_Pc;
    logic [DW-1:0] Dn_Instr;
    logic [1:0]    Occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    ifid_skid_stage #(.DW(DW)) dut (
        .Clk       (Clk),
        .Rst_N     (Rst_N),
        .Flush     (Flush),
        .Up_Valid  (Up_Valid),
        .Up_Ready  (Up_Ready),
        .Up_Pc     (Up_Pc),
        .Up_Instr  (Up_Instr),
        .Dn_Valid  (Dn_Valid),
        .Dn_Ready  (Dn_Ready),
        .Dn_Pc     (Dn_Pc),
        .Dn_Instr  (Dn_Instr),
        .Occupancy (Occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive_up(input logic v, input logic [DW-1:0] pc);
        Up_Valid = v;
        Up_Pc    = pc;
        Up_Instr = instr_of(pc);
    endtask

    logic [2*DW-1:0] q[$];
    logic [2*DW-1:0] head;
    logic            acc, cons;
    int unsigned     pc_ctr;

    initial begin
        Rst_N    = 1'b0;
        Flush    = 1'b0;
        Dn_Ready = 1'b0;
        drive_up(1'b0, '0);

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            Flush    = 1'($urandom);
            Dn_Ready = 1'($urandom);
            drive_up(1'($urandom), $urandom);
            cyc();
            chk("rst_dn_valid", 64'(Dn_Valid), 64'(0));
            chk("rst_occ", 64'(Occupancy), 64'(0));
            chk("rst_up_ready", 64'(Up_Ready), 64'(1));
            chk("rst_dn_pc", 64'(Dn_Pc), 64'(0));
        end
        Flush    = 1'b0;
        Dn_Ready = 1'b0;
        drive_up(1'b0, '0);
        Rst_N = 1'b1;
        cyc();
        chk("post_rst_occ", 64'(Occupancy), 64'(0));

        // Streaming: one entry per cycle with 1-cycle latency.
        Dn_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_up(1'b1, 32'(i * 4));
            cyc();
            chk("stream_valid", 64'(Dn_Valid), 64'(1));
            chk("stream_pc", 64'(Dn_Pc), 64'(i * 4));
            chk("stream_instr", 64'(Dn_Instr), 64'(instr_of(32'(i * 4))));
            chk("stream_occ", 64'(Occupancy), 64'(1));
        end
        drive_up(1'b0, '0);
        cyc();
        chk("stream_drain_occ", 64'(Occupancy), 64'(0));
        chk("stream_drain_valid", 64'(Dn_Valid), 64'(0));

        // Back-pressure fills the skid slot and holds the head stable.
        Dn_Ready = 1'b0;
        drive_up(1'b1, 32'h10);
        cyc();
        chk("bp_occ1", 64'(Occupancy), 64'(1));
        chk("bp_pc1", 64'(Dn_Pc), 64'h10);
        drive_up(1'b1, 32'h14);
        cyc();
        chk("bp_occ2", 64'(Occupancy), 64'(2));
        chk("bp_up_ready", 64'(Up_Ready), 64'(0));
        chk("bp_pc_held", 64'(Dn_Pc), 64'h10);
        drive_up(1'b1, 32'h18);
        cyc();
        chk("bp_full_hold_occ", 64'(Occupancy), 64'(2));
        chk("bp_full_hold_pc", 64'(Dn_Pc), 64'h10);
        drive_up(1'b0, '0);
        Dn_Ready = 1'b1;
        cyc();
        chk("bp_second_pc", 64'(Dn_Pc), 64'h14);
        chk("bp_second_instr", 64'(Dn_Instr), 64'(instr_of(32'h14)));
        chk("bp_second_occ", 64'(Occupancy), 64'(1));
        chk("bp_up_ready_back", 64'(Up_Ready), 64'(1));
        cyc();
        chk("bp_empty_valid", 64'(Dn_Valid), 64'(0));
        chk("bp_empty_occ", 64'(Occupancy), 64'(0));

        // Flush while full, with a concurrent accept and consume offered.
        Dn_Ready = 1'b0;
        drive_up(1'b1, 32'h20);
        cyc();
        drive_up(1'b1, 32'h24);
        cyc();
        chk("fl_pre_occ", 64'(Occupancy), 64'(2));
        Flush    = 1'b1;
        Dn_Ready = 1'b1;
        drive_up(1'b1, 32'h28);
        cyc();
        chk("fl_valid", 64'(Dn_Valid), 64'(0));
        chk("fl_occ", 64'(Occupancy), 64'(0));
        chk("fl_up_ready", 64'(Up_Ready), 64'(1));
        Flush = 1'b0;
        drive_up(1'b0, '0);
        cyc();
        chk("fl_after_valid", 64'(Dn_Valid), 64'(0));
        chk("fl_after_occ", 64'(Occupancy), 64'(0));

        // Asynchronous reset between edges while full.
        Dn_Ready = 1'b0;
        drive_up(1'b1, 32'h30);
        cyc();
        drive_up(1'b1, 32'h34);
        cyc();
        chk("ar_pre_occ", 64'(Occupancy), 64'(2));
        drive_up(1'b0, '0);
        #2 Rst_N = 1'b0;
        #1;
        chk("ar_valid", 64'(Dn_Valid), 64'(0));
        chk("ar_occ", 64'(Occupancy), 64'(0));
        chk("ar_up_ready", 64'(Up_Ready), 64'(1));
        chk("ar_pc", 64'(Dn_Pc), 64'(0));
        #1 Rst_N = 1'b1;
        Dn_Ready = 1'b1;
        drive_up(1'b1, 32'h40);
        cyc();
        chk("ar_fresh_pc", 64'(Dn_Pc), 64'h40);
        chk("ar_fresh_valid", 64'(Dn_Valid), 64'(1));
        chk("ar_fresh_occ", 64'(Occupancy), 64'(1));
        drive_up(1'b0, '0);
        cyc();
        chk("ar_fresh_drain", 64'(Occupancy), 64'(0));

        // Random traffic against a reference FIFO of depth two.
        q.delete();
        pc_ctr = 32'h100;
        for (int i = 0; i < 10000; i++) begin
            Flush    = ($urandom_range(0, 19) == 0);
            Dn_Ready = 1'($urandom);
            drive_up(1'($urandom), pc_ctr);
            Up_Instr = $urandom;
            pc_ctr   = pc_ctr + 4;
            acc  = Up_Valid && (q.size() < 2);
            cons = Dn_Ready && (q.size() > 0);
            cyc();
            if (Flush) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back({Up_Pc, Up_Instr});
            end
            chk("rnd_occ", 64'(Occupancy), 64'(q.size()));
            chk("rnd_valid", 64'(Dn_Valid), 64'(q.size() > 0));
            chk("rnd_up_ready", 64'(Up_Ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                head = q[0];
                chk("rnd_head", {Dn_Pc, Dn_Instr}, head);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
